axil_memory_arbiter: RTL and testbench

Two-master to one-slave AXI4-Lite arbiter that lets the CPU instruction fetch port and data memory port share a single memory slave, such as the DDR controller bridge. It sits between the `cpu` top level's instruction and data AXI-Lite master ports and the memory slave. It serializes traffic to one outstanding transaction at a time and uses round-robin grant between the two masters.

---
 rtl/axil_memory_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axil_memory_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_memory_arbiter.sv
// Two-master (instruction fetch, data) to one-slave AXI4-Lite arbiter.
// One transaction in flight at a time; round-robin between masters on ties.
module axil_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_Clock,
    input  logic                    w_Reset,

    input  logic [ADDR_WIDTH-1:0]   s_instr_axil_araddr,
    input  logic                    s_instr_axil_arvalid,
    output logic                    s_instr_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_instr_axil_rdata,
    output logic                    s_instr_axil_rvalid,
    input  logic                    s_instr_axil_rready,

    input  logic [ADDR_WIDTH-1:0]   s_data_axil_araddr,
    input  logic                    s_data_axil_arvalid,
    output logic                    s_data_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_data_axil_rdata,
    output logic                    s_data_axil_rvalid,
    input  logic                    s_data_axil_rready,
    input  logic [ADDR_WIDTH-1:0]   s_data_axil_awaddr,
    input  logic                    s_data_axil_awvalid,
    output logic                    s_data_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_data_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_data_axil_wstrb,
    input  logic                    s_data_axil_wvalid,
    output logic                    s_data_axil_wready,
    output logic [1:0]              s_data_axil_bresp,
    output logic                    s_data_axil_bvalid,
    input  logic                    s_data_axil_bready,

    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,

    output logic [1:0]              o_Grant
);

    // Encoding doubles as the debug grant code.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        INSTR_RD = 2'b01,
        DATA_RD  = 2'b10,
        DATA_WR  = 2'b11
    } state_t;

    state_t state_q;
    state_t arb_state_d;
    logic   last_data_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic instr_req;
    logic data_req;
    logic grant_data;

    assign instr_req  = s_instr_axil_arvalid;
    assign data_req   = s_data_axil_awvalid | s_data_axil_arvalid;
    assign grant_data = data_req && (!instr_req || !last_data_q);

    always_comb begin
        arb_state_d = IDLE;
        if (grant_data)
            arb_state_d = s_data_axil_awvalid ? DATA_WR : DATA_RD;
        else if (instr_req)
            arb_state_d = INSTR_RD;
    end

    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            ar_done_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_state_d != IDLE) begin
                        state_q     <= arb_state_d;
                        last_data_q <= (arb_state_d != INSTR_RD);
                    end
                end
                INSTR_RD, DATA_RD: begin
                    if (m_axil_arvalid && m_axil_arready)
                        ar_done_q <= 1'b1;
                    if (m_axil_rvalid && m_axil_rready) begin
                        state_q   <= IDLE;
                        ar_done_q <= 1'b0;
                    end
                end
                DATA_WR: begin
                    if (m_axil_awvalid && m_axil_awready)
                        aw_done_q <= 1'b1;
                    if (m_axil_wvalid && m_axil_wready)
                        w_done_q <= 1'b1;
                    if (m_axil_bvalid && m_axil_bready) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Grant = state_q;

    // Routing: everything idles at zero unless the owning state forwards it.
    always_comb begin
        s_instr_axil_arready = 1'b0;
        s_instr_axil_rdata   = '0;
        s_instr_axil_rvalid  = 1'b0;
        s_data_axil_arready  = 1'b0;
        s_data_axil_rdata    = '0;
        s_data_axil_rvalid   = 1'b0;
        s_data_axil_awready  = 1'b0;
        s_data_axil_wready   = 1'b0;
        s_data_axil_bresp    = 2'b00;
        s_data_axil_bvalid   = 1'b0;
        m_axil_araddr        = '0;
        m_axil_arvalid       = 1'b0;
        m_axil_rready        = 1'b0;
        m_axil_awaddr        = '0;
        m_axil_awvalid       = 1'b0;
        m_axil_wdata         = '0;
        m_axil_wstrb         = '0;
        m_axil_wvalid        = 1'b0;
        m_axil_bready        = 1'b0;
        case (state_q)
            INSTR_RD: begin
                m_axil_araddr        = s_instr_axil_araddr;
                m_axil_arvalid       = s_instr_axil_arvalid && !ar_done_q;
                s_instr_axil_arready = m_axil_arready && !ar_done_q;
                m_axil_rready        = s_instr_axil_rready;
                s_instr_axil_rvalid  = m_axil_rvalid;
                s_instr_axil_rdata   = m_axil_rdata;
            end
            DATA_RD: begin
                m_axil_araddr       = s_data_axil_araddr;
                m_axil_arvalid      = s_data_axil_arvalid && !ar_done_q;
                s_data_axil_arready = m_axil_arready && !ar_done_q;
                m_axil_rready       = s_data_axil_rready;
                s_data_axil_rvalid  = m_axil_rvalid;
                s_data_axil_rdata   = m_axil_rdata;
            end
            DATA_WR: begin
                m_axil_awaddr       = s_data_axil_awaddr;
                m_axil_awvalid      = s_data_axil_awvalid && !aw_done_q;
                s_data_axil_awready = m_axil_awready && !aw_done_q;
                m_axil_wdata        = s_data_axil_wdata;
                m_axil_wstrb        = s_data_axil_wstrb;
                m_axil_wvalid       = s_data_axil_wvalid && !w_done_q;
                s_data_axil_wready  = m_axil_wready && !w_done_q;
                m_axil_bready       = s_data_axil_bready;
                s_data_axil_bvalid  = m_axil_bvalid;
                s_data_axil_bresp   = m_axil_bresp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_memory_arbiter.sv
// Directed bench for axil_memory_arbiter: hand-driven masters and slave,
// hand-computed expectations, one line per completed transaction.
module tb_axil_memory_arbiter;

    logic        i_Clock = 1'b0;
    logic        w_Reset;
    logic [31:0] s_instr_axil_araddr;
    logic        s_instr_axil_arvalid, s_instr_axil_arready;
    logic [31:0] s_instr_axil_rdata;
    logic        s_instr_axil_rvalid, s_instr_axil_rready;
    logic [31:0] s_data_axil_araddr, s_data_axil_awaddr, s_data_axil_wdata, s_data_axil_rdata;
    logic [3:0]  s_data_axil_wstrb;
    logic        s_data_axil_arvalid, s_data_axil_arready, s_data_axil_rvalid, s_data_axil_rready;
    logic        s_data_axil_awvalid, s_data_axil_awready, s_data_axil_wvalid, s_data_axil_wready;
    logic [1:0]  s_data_axil_bresp;
    logic        s_data_axil_bvalid, s_data_axil_bready;
    logic [31:0] m_axil_araddr, m_axil_awaddr, m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid, m_axil_bready;
    logic [1:0]  o_Grant;

    int total = 0;
    int bad   = 0;

    always #5 i_Clock = ~i_Clock;

    axil_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_Clock(i_Clock), .w_Reset(w_Reset),
        .s_instr_axil_araddr(s_instr_axil_araddr), .s_instr_axil_arvalid(s_instr_axil_arvalid),
        .s_instr_axil_arready(s_instr_axil_arready), .s_instr_axil_rdata(s_instr_axil_rdata),
        .s_instr_axil_rvalid(s_instr_axil_rvalid), .s_instr_axil_rready(s_instr_axil_rready),
        .s_data_axil_araddr(s_data_axil_araddr), .s_data_axil_arvalid(s_data_axil_arvalid),
        .s_data_axil_arready(s_data_axil_arready), .s_data_axil_rdata(s_data_axil_rdata),
        .s_data_axil_rvalid(s_data_axil_rvalid), .s_data_axil_rready(s_data_axil_rready),
        .s_data_axil_awaddr(s_data_axil_awaddr), .s_data_axil_awvalid(s_data_axil_awvalid),
        .s_data_axil_awready(s_data_axil_awready), .s_data_axil_wdata(s_data_axil_wdata),
        .s_data_axil_wstrb(s_data_axil_wstrb), .s_data_axil_wvalid(s_data_axil_wvalid),
        .s_data_axil_wready(s_data_axil_wready), .s_data_axil_bresp(s_data_axil_bresp),
        .s_data_axil_bvalid(s_data_axil_bvalid), .s_data_axil_bready(s_data_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready), .m_axil_rdata(m_axil_rdata),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata),
        .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .o_Grant(o_Grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic clear_inputs();
        s_instr_axil_araddr = '0; s_instr_axil_arvalid = 0; s_instr_axil_rready = 0;
        s_data_axil_araddr = '0; s_data_axil_arvalid = 0; s_data_axil_rready = 0;
        s_data_axil_awaddr = '0; s_data_axil_awvalid = 0; s_data_axil_wdata = '0;
        s_data_axil_wstrb = '0; s_data_axil_wvalid = 0; s_data_axil_bready = 0;
        m_axil_arready = 0; m_axil_rdata = '0; m_axil_rvalid = 0; m_axil_awready = 0;
        m_axil_wready = 0; m_axil_bresp = 2'b00; m_axil_bvalid = 0;
    endtask

    // Always-ready slave; R one cycle after AR, B one cycle after both AW and W.
    // exp_seq holds expected grants, element k in bits [2k+1:2k].
    task automatic run_auto(input int n_instr, input int n_rd, input int n_wr,
                            input logic [15:0] exp_seq, input int n_exp);
        int il, rl, wl, done_n;
        logic rv, bv, aw_got, w_got, rv_n, bv_n;
        logic [31:0] cur_rdata, next_rdata;
        logic [1:0] g;
        il = n_instr; rl = n_rd; wl = n_wr; done_n = 0;
        rv = 0; bv = 0; aw_got = 0; w_got = 0; next_rdata = '0;
        s_instr_axil_araddr = 32'h80; s_data_axil_araddr = 32'h300;
        s_data_axil_awaddr = 32'h304; s_data_axil_wdata = 32'h1234_5678; s_data_axil_wstrb = 4'hF;
        s_instr_axil_rready = 1; s_data_axil_rready = 1; s_data_axil_bready = 1;
        m_axil_arready = 1; m_axil_awready = 1; m_axil_wready = 1; m_axil_bresp = 2'b00;
        for (int cyc = 0; cyc < 200 && done_n < n_exp; cyc++) begin
            s_instr_axil_arvalid = (il > 0);
            s_data_axil_arvalid  = (rl > 0);
            s_data_axil_awvalid  = (wl > 0);
            s_data_axil_wvalid   = (wl > 0);
            cur_rdata     = next_rdata;
            m_axil_rvalid = rv;
            m_axil_rdata  = cur_rdata;
            m_axil_bvalid = bv;
            #1;
            rv_n = rv; bv_n = bv;
            if (m_axil_arvalid) begin
                rv_n = 1;
                next_rdata = 32'hC0DE_0000 + 32'(cyc);
            end
            if (m_axil_awvalid) aw_got = 1;
            if (m_axil_wvalid)  w_got  = 1;
            if (m_axil_rvalid && m_axil_rready) begin
                g = o_Grant;
                chk("auto_grant", g, exp_seq[2*done_n +: 2]);
                chk("auto_rdata", (g == 2'b01) ? s_instr_axil_rdata : s_data_axil_rdata, cur_rdata);
                if (g == 2'b01) il--; else rl--;
                $display("txn %0d: read grant=%b rdata=%08h", done_n, g, cur_rdata);
                rv_n = 0;
                done_n++;
            end
            if (m_axil_bvalid && m_axil_bready) begin
                g = o_Grant;
                chk("auto_grant", g, exp_seq[2*done_n +: 2]);
                chk("auto_bvalid", s_data_axil_bvalid, 1);
                $display("txn %0d: write grant=%b", done_n, g);
                wl--;
                bv_n = 0;
                done_n++;
            end
            if (aw_got && w_got) begin
                bv_n = 1; aw_got = 0; w_got = 0;
            end
            rv = rv_n; bv = bv_n;
            tick();
        end
        chk("auto_done", done_n, n_exp);
        clear_inputs();
        #1;
    endtask

    initial begin
        clear_inputs();
        // Reset with slave noise present: every output must stay 0.
        w_Reset = 1;
        m_axil_arready = 1; m_axil_rvalid = 1; m_axil_rdata = 32'hAA;
        tick(); tick(); #1;
        chk("rst_grant", o_Grant, 0);
        chk("rst_m_arvalid", m_axil_arvalid, 0);
        chk("rst_i_rvalid", s_instr_axil_rvalid, 0);
        chk("rst_i_rdata", s_instr_axil_rdata, 0);
        chk("rst_m_rready", m_axil_rready, 0);
        w_Reset = 0;
        clear_inputs();
        tick();

        // Single instruction fetch, response 3 cycles after AR.
        s_instr_axil_araddr = 32'h10; s_instr_axil_arvalid = 1; s_instr_axil_rready = 1; #1;
        chk("t1_idle_grant", o_Grant, 0);
        chk("t1_idle_arvalid", m_axil_arvalid, 0);
        tick(); #1;
        chk("t1_grant", o_Grant, 2'b01);
        chk("t1_arvalid", m_axil_arvalid, 1);
        chk("t1_araddr", m_axil_araddr, 32'h10);
        m_axil_arready = 1; #1;
        chk("t1_arready", s_instr_axil_arready, 1);
        tick(); #1;
        chk("t1_ar_done_mask", m_axil_arvalid, 0);
        s_instr_axil_arvalid = 0; m_axil_arready = 0;
        tick(); tick();
        m_axil_rvalid = 1; m_axil_rdata = 32'h13; #1;
        chk("t1_i_rvalid", s_instr_axil_rvalid, 1);
        chk("t1_i_rdata", s_instr_axil_rdata, 32'h13);
        chk("t1_m_rready", m_axil_rready, 1);
        chk("t1_d_rvalid", s_data_axil_rvalid, 0);
        tick(); m_axil_rvalid = 0; m_axil_rdata = '0; #1;
        chk("t1_back_idle", o_Grant, 0);
        $display("txn t1: instr read 0x10 -> 0x13");

        // Data store, W accepted 2 cycles before AW.
        s_data_axil_awaddr = 32'h100; s_data_axil_awvalid = 1;
        s_data_axil_wdata = 32'hDEADBEEF; s_data_axil_wstrb = 4'hF; s_data_axil_wvalid = 1;
        s_data_axil_bready = 1; #1;
        chk("t2_idle_grant", o_Grant, 0);
        tick(); #1;
        chk("t2_grant", o_Grant, 2'b11);
        chk("t2_awvalid", m_axil_awvalid, 1);
        chk("t2_wvalid", m_axil_wvalid, 1);
        chk("t2_awaddr", m_axil_awaddr, 32'h100);
        chk("t2_wdata", m_axil_wdata, 32'hDEADBEEF);
        chk("t2_wstrb", m_axil_wstrb, 4'hF);
        m_axil_wready = 1; #1;
        chk("t2_wready", s_data_axil_wready, 1);
        chk("t2_awready_low", s_data_axil_awready, 0);
        tick(); #1;
        chk("t2_w_done_mask", m_axil_wvalid, 0);
        chk("t2_w_done_ready", s_data_axil_wready, 0);
        s_data_axil_wvalid = 0; m_axil_wready = 0;
        tick();
        m_axil_awready = 1; #1;
        chk("t2_awready", s_data_axil_awready, 1);
        chk("t2_i_rvalid_a", s_instr_axil_rvalid, 0);
        tick(); #1;
        chk("t2_aw_done_mask", m_axil_awvalid, 0);
        chk("t2_grant_hold", o_Grant, 2'b11);
        s_data_axil_awvalid = 0; m_axil_awready = 0;
        m_axil_bvalid = 1; m_axil_bresp = 2'b00; #1;
        chk("t2_bvalid", s_data_axil_bvalid, 1);
        chk("t2_bresp", s_data_axil_bresp, 2'b00);
        chk("t2_bready", m_axil_bready, 1);
        chk("t2_i_rvalid_b", s_instr_axil_rvalid, 0);
        tick(); m_axil_bvalid = 0; #1;
        chk("t2_back_idle", o_Grant, 0);
        chk("t2_bvalid_off", s_data_axil_bvalid, 0);
        clear_inputs();
        $display("txn t2: data write 0x100 <- deadbeef");

        // Simultaneous reads out of reset: data first, then strict alternation.
        w_Reset = 1; tick(); w_Reset = 0;
        run_auto(4, 4, 0, {2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2}, 8);

        // AW and AR together: write first, then the read.
        run_auto(0, 1, 1, 16'h000B, 2);

        // Instr request during an outstanding data read.
        s_data_axil_araddr = 32'h200; s_data_axil_arvalid = 1; s_data_axil_rready = 1;
        tick(); #1;
        chk("t5_grant_data", o_Grant, 2'b10);
        chk("t5_araddr", m_axil_araddr, 32'h200);
        m_axil_arready = 1;
        tick();
        s_data_axil_arvalid = 0;
        s_instr_axil_araddr = 32'h40; s_instr_axil_arvalid = 1; s_instr_axil_rready = 1; #1;
        chk("t5_i_arready_a", s_instr_axil_arready, 0);
        tick(); #1;
        chk("t5_i_arready_b", s_instr_axil_arready, 0);
        m_axil_rvalid = 1; m_axil_rdata = 32'h55; #1;
        chk("t5_d_rdata", s_data_axil_rdata, 32'h55);
        chk("t5_i_rvalid", s_instr_axil_rvalid, 0);
        chk("t5_i_arready_c", s_instr_axil_arready, 0);
        tick(); m_axil_rvalid = 0; #1;
        chk("t5_idle_gap", o_Grant, 0);
        chk("t5_i_arready_d", s_instr_axil_arready, 0);
        tick(); #1;
        chk("t5_grant_instr", o_Grant, 2'b01);
        chk("t5_i_arready_e", s_instr_axil_arready, 1);
        chk("t5_i_araddr", m_axil_araddr, 32'h40);
        tick();
        s_instr_axil_arvalid = 0; m_axil_arready = 0;
        m_axil_rvalid = 1; m_axil_rdata = 32'h77; #1;
        chk("t5_i_rdata", s_instr_axil_rdata, 32'h77);
        tick(); clear_inputs(); #1;
        chk("t5_back_idle", o_Grant, 0);
        $display("txn t5: data read then instr read after one idle cycle");

        // Reset during DATA_WR after the AW handshake.
        s_data_axil_awaddr = 32'h180; s_data_axil_awvalid = 1;
        s_data_axil_wdata = 32'h0BAD_F00D; s_data_axil_wstrb = 4'h3; s_data_axil_wvalid = 1;
        s_data_axil_bready = 1;
        tick(); #1;
        chk("t6_grant_wr", o_Grant, 2'b11);
        m_axil_awready = 1;
        tick();
        s_data_axil_awvalid = 0; m_axil_awready = 0; w_Reset = 1; #1;
        chk("t6_aw_done", m_axil_awvalid, 0);
        tick();
        w_Reset = 0; m_axil_wready = 1; #1;
        chk("t6_rst_grant", o_Grant, 0);
        chk("t6_rst_wvalid", m_axil_wvalid, 0);
        chk("t6_rst_wready", s_data_axil_wready, 0);
        chk("t6_rst_wdata", m_axil_wdata, 0);
        chk("t6_rst_bready", m_axil_bready, 0);
        clear_inputs();
        tick();
        run_auto(1, 0, 0, 16'h0001, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
